// File: rtl/throttle_req_gen.sv
// Round-robin request generator feeding the throttle: per-queue pending counts and burst lengths.
// Optional accepted-request counter (grant_total) is built when THROTTLE_REQ_STATS_EN is defined.
module throttle_req_gen #(
  parameter int NUM_Q = 4,
  parameter int ID_W  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            load,
  input  logic [ID_W-1:0] load_id,
  input  logic [15:0]     load_cnt,
  input  logic [3:0]      load_len,
  output logic            valid,
  output logic [ID_W-1:0] id,
  output logic [3:0]      len,
  input  logic            ready,
  output logic            busy,
  output logic            done,
`ifdef THROTTLE_REQ_STATS_EN
  output logic [31:0]     grant_total,
`endif
  output logic [1:0]      debug_state
);

  // Handshake: valid/id/len are held constant from REQ entry until a cycle in which
  // ready=1 is sampled while valid=1; ready seen outside REQ is ignored.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    REQ  = 2'd2
  } state_t;

  state_t          state;
  logic [15:0]     cnt      [NUM_Q];
  logic [15:0]     cnt_next [NUM_Q];
  logic [3:0]      qlen     [NUM_Q];
  logic [ID_W-1:0] rr_ptr;
  logic [3:0]      load_len_eff;
  logic            accept;
  logic            any_now;
  logic            any_next;
  logic            pick_found;
  logic [ID_W-1:0] pick_id;
  logic [ID_W-1:0] scan_idx;

  assign accept       = (state == REQ) && ready;
  assign load_len_eff = (load_len == 4'd0) ? 4'd1 : load_len;
  assign busy         = (state != IDLE);
  assign debug_state  = state;

  // A load to the accepted queue overrides its decrement in the same cycle.
  always_comb begin
    for (int q = 0; q < NUM_Q; q++) begin
      cnt_next[q] = cnt[q];
      if (accept && (id == ID_W'(q)) && (cnt[q] != 16'd0))
        cnt_next[q] = cnt[q] - 16'd1;
      if (load && (load_id == ID_W'(q)))
        cnt_next[q] = load_cnt;
    end
  end

  always_comb begin
    any_now  = 1'b0;
    any_next = 1'b0;
    for (int q = 0; q < NUM_Q; q++) begin
      if (cnt[q] != 16'd0)      any_now  = 1'b1;
      if (cnt_next[q] != 16'd0) any_next = 1'b1;
    end
  end

  // Scan starts one past the last grant and wraps, so every queue gets a turn.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    scan_idx   = '0;
    for (int i = 1; i <= NUM_Q; i++) begin
      scan_idx = ID_W'((int'(rr_ptr) + i) % NUM_Q);
      if (!pick_found && (cnt[scan_idx] != 16'd0)) begin
        pick_found = 1'b1;
        pick_id    = scan_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int q = 0; q < NUM_Q; q++) begin
        cnt[q]  <= 16'd0;
        qlen[q] <= 4'd0;
      end
    end else begin
      for (int q = 0; q < NUM_Q; q++) begin
        cnt[q] <= cnt_next[q];
        if (load && (load_id == ID_W'(q)))
          qlen[q] <= load_len_eff;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      valid  <= 1'b0;
      id     <= '0;
      len    <= 4'd0;
      done   <= 1'b0;
      rr_ptr <= ID_W'(NUM_Q - 1);
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && any_now)
            state <= ARB;
        end
        ARB: begin
          if (pick_found) begin
            state  <= REQ;
            valid  <= 1'b1;
            id     <= pick_id;
            len    <= qlen[pick_id];
            rr_ptr <= pick_id;
          end else begin
            state <= IDLE;
          end
        end
        REQ: begin
          if (ready) begin
            valid <= 1'b0;
            done  <= !any_next;
            state <= (enable && any_next) ? ARB : IDLE;
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef THROTTLE_REQ_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      grant_total <= 32'd0;
    else if (accept)
      grant_total <= grant_total + 32'd1;
  end
`endif

endmodule

// File: tb/tb_throttle_req_gen.sv
// Scenario bench for throttle_req_gen: expected {id,len} pairs are queued when queues are
// loaded and popped as requests appear; grant_total is checked only when the stats build is on.
`timescale 1ns/1ps
module tb_throttle_req_gen;
  localparam int NUM_Q = 4;
  localparam int ID_W  = 2;
  localparam int W     = ID_W + 4;

  logic            clk;
  logic            reset;
  logic            enable;
  logic            load;
  logic [ID_W-1:0] load_id;
  logic [15:0]     load_cnt;
  logic [3:0]      load_len;
  logic            valid;
  logic [ID_W-1:0] id;
  logic [3:0]      len;
  logic            ready;
  logic            busy;
  logic            done;
  logic [1:0]      debug_state;
`ifdef THROTTLE_REQ_STATS_EN
  logic [31:0]     grant_total;
`endif

  int checks;
  int errors;
  int exp_grants;
  logic [W-1:0] exp_q[$];

  throttle_req_gen #(.NUM_Q(NUM_Q), .ID_W(ID_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .load_id    (load_id),
    .load_cnt   (load_cnt),
    .load_len   (load_len),
    .valid      (valid),
    .id         (id),
    .len        (len),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
`ifdef THROTTLE_REQ_STATS_EN
    .grant_total(grant_total),
`endif
    .debug_state(debug_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: time=%0t required completion before 1ms", $time);
    $fatal(1, "watchdog expired");
  end

  // driver tasks: all start and end just after a falling edge
  task automatic apply_reset();
    reset = 1'b0; enable = 1'b0; load = 1'b0; ready = 1'b0;
    load_id = '0; load_cnt = 16'd0; load_len = 4'd0;
    exp_grants = 0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_q(input logic [ID_W-1:0] q, input logic [15:0] c, input logic [3:0] l);
    load = 1'b1; load_id = q; load_cnt = c; load_len = l;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (valid !== 1'b1 && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic serve(input int n, input int delay);
    logic [W-1:0] exp;
    int gap;
    for (int k = 0; k < n; k++) begin
      wait_valid(gap);
      checks++;
      if (valid !== 1'b1) begin
        $display("FAIL serve_timeout: valid=%b required 1 within 50 cycles (req %0d)", valid, k);
        errors++;
        return;
      end
      if (k > 0) begin
        checks++;
        if (gap !== 1) begin
          $display("FAIL valid_gap: low cycles=%0d required 1 (req %0d)", gap, k);
          errors++;
        end
      end
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      checks++;
      if ({id, len} !== exp) begin
        $display("FAIL req_fields: id=%0d len=%0d required id=%0d len=%0d (req %0d)",
                 id, len, exp[W-1:4], exp[3:0], k);
        errors++;
      end
      repeat (delay) @(negedge clk);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      exp_grants++;
      checks++;
      if (valid !== 1'b0 || done !== (k == n - 1) || busy !== (k != n - 1)) begin
        $display("FAIL after_accept: valid=%b done=%b busy=%b required valid=0 done=%b busy=%b (req %0d)",
                 valid, done, busy, (k == n - 1), (k != n - 1), k);
        errors++;
      end
    end
`ifdef THROTTLE_REQ_STATS_EN
    checks++;
    if (grant_total !== 32'(exp_grants)) begin
      $display("FAIL grant_total: got %0d required %0d", grant_total, exp_grants);
      errors++;
    end
`endif
  endtask

  // scenarios
  task automatic test_reset();
    apply_reset();
    checks++;
    if (valid !== 1'b0 || id !== '0 || len !== 4'd0 || busy !== 1'b0 || done !== 1'b0 ||
        debug_state !== 2'd0) begin
      $display("FAIL reset_values: valid=%b id=%0d len=%0d busy=%b done=%b state=%0d required all 0",
               valid, id, len, busy, done, debug_state);
      errors++;
    end
`ifdef THROTTLE_REQ_STATS_EN
    checks++;
    if (grant_total !== 32'd0) begin
      $display("FAIL reset_grant_total: got %0d required 0", grant_total);
      errors++;
    end
`endif
  endtask

  task automatic test_basic();
    apply_reset();
    load_q(2'd0, 16'd3, 4'd2);
    repeat (3) exp_q.push_back({2'd0, 4'd2});
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL enable_to_arb: valid=%b busy=%b required valid=0 busy=1", valid, busy);
      errors++;
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b1) begin
      $display("FAIL enable_to_valid: valid=%b required 1 two cycles after enable", valid);
      errors++;
    end
    serve(3, 1);
  endtask

  task automatic test_round_robin();
    apply_reset();
    load_q(2'd0, 16'd2, 4'd1);
    load_q(2'd1, 16'd2, 4'd4);
    load_q(2'd2, 16'd0, 4'd2);
    load_q(2'd3, 16'd2, 4'd7);
    repeat (2) begin
      exp_q.push_back({2'd0, 4'd1});
      exp_q.push_back({2'd1, 4'd4});
      exp_q.push_back({2'd3, 4'd7});
    end
    enable = 1'b1;
    serve(6, 0);
  endtask

  task automatic test_hold();
    int cyc;
    logic stable_ok;
    apply_reset();
    load_q(2'd1, 16'd2, 4'd3);
    enable = 1'b1;
    wait_valid(cyc);
    checks++;
    if (valid !== 1'b1 || id !== 2'd1 || len !== 4'd3) begin
      $display("FAIL hold_first: valid=%b id=%0d len=%0d required valid=1 id=1 len=3", valid, id, len);
      errors++;
    end
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (valid !== 1'b1 || id !== 2'd1 || len !== 4'd3) begin
        $display("FAIL hold_stable: cycle %0d valid=%b id=%0d len=%0d required valid=1 id=1 len=3",
                 c, valid, id, len);
        errors++;
      end
      enable = c[0];
      load = (c == 5);
      load_id = 2'd1; load_cnt = 16'd2; load_len = 4'd9;
      @(negedge clk);
    end
    load = 1'b0;
    enable = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    exp_grants++;
    stable_ok = (valid === 1'b0) && (busy === 1'b1) && (done === 1'b0);
    checks++;
    if (!stable_ok) begin
      $display("FAIL hold_accept: valid=%b busy=%b done=%b required valid=0 busy=1 done=0", valid, busy, done);
      errors++;
    end
    exp_q.push_back({2'd1, 4'd9});
    serve(1, 0);
  endtask

  task automatic test_load_collision();
    int cyc;
    apply_reset();
    load_q(2'd1, 16'd5, 4'd1);
    enable = 1'b1;
    wait_valid(cyc);
    checks++;
    if (valid !== 1'b1 || id !== 2'd1) begin
      $display("FAIL collide_first: valid=%b id=%0d required valid=1 id=1", valid, id);
      errors++;
    end
    ready = 1'b1;
    load = 1'b1; load_id = 2'd1; load_cnt = 16'd7; load_len = 4'd1;
    @(negedge clk);
    ready = 1'b0;
    load = 1'b0;
    exp_grants++;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      $display("FAIL collide_accept: valid=%b busy=%b done=%b required valid=0 busy=1 done=0", valid, busy, done);
      errors++;
    end
    repeat (7) exp_q.push_back({2'd1, 4'd1});
    serve(7, 0);
  endtask

  task automatic test_len_zero();
    apply_reset();
    load_q(2'd2, 16'd1, 4'd0);
    exp_q.push_back({2'd2, 4'd1});
    enable = 1'b1;
    serve(1, 0);
  endtask

  task automatic test_reset_mid_req();
    int cyc;
    logic quiet;
    apply_reset();
    load_q(2'd0, 16'd4, 4'd5);
    enable = 1'b1;
    wait_valid(cyc);
    checks++;
    if (valid !== 1'b1 || id !== 2'd0 || len !== 4'd5) begin
      $display("FAIL rst_pre: valid=%b id=%0d len=%0d required valid=1 id=0 len=5", valid, id, len);
      errors++;
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL rst_async: valid=%b busy=%b done=%b required all 0", valid, busy, done);
      errors++;
    end
    @(negedge clk);
    reset = 1'b1;
    exp_grants = 0;
    quiet = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      $display("FAIL rst_no_request: valid=%b busy=%b done=%b required 0 after reset release", valid, busy, done);
      errors++;
    end
    load_q(2'd3, 16'd1, 4'd4);
    exp_q.push_back({2'd3, 4'd4});
    serve(1, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_grants = 0;
    reset = 1'b0; enable = 1'b0; load = 1'b0; ready = 1'b0;
    load_id = '0; load_cnt = 16'd0; load_len = 4'd0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_round_robin();
    test_hold();
    test_load_collision();
    test_len_zero();
    test_reset_mid_req();
    checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
      errors++;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/throttle_req_gen.md
# throttle_req_gen

Request generator that drives the throttle's request side in the synthetic traffic bench. It holds a per-queue pending-request count and burst length, and picks a non-empty queue round-robin. It presents valid/id/len to the throttle and holds them stable until the throttle's one-cycle ready pulse accepts the request. It sits between the bench's traffic configuration logic and the per-queue throttle instance.

## Interface
- NUM_Q, 4: number of request queues (2..16)
- ID_W, 2: queue id width, equal to log2(NUM_Q)
- clk  input  1  clock; all state updates on posedge
- reset  input  1  asynchronous, active-low
- enable  input  1  allows new requests to start; sampled only in IDLE and at handshake completion
- load  input  1  one-cycle strobe writing load_cnt and load_len into queue load_id
- load_id  input  ID_W  target queue for load
- load_cnt  input  16  pending request count for the queue
- load_len  input  4  burst length for the queue's requests
- valid  output  1  request present
- id  output  ID_W  queue id of the presented request
- len  output  4  burst length of the presented request
- ready  input  1  one-cycle accept pulse from the throttle
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse when the last pending request in all queues is accepted
- grant_total  output  32  accepted-request counter (only with THROTTLE_REQ_STATS_EN)

## Operation
- Per queue: cnt[15:0] and qlen[3:0]. Reset value is 0 for both.
- A load writes cnt and qlen. A load_len of 0 is stored as 1.
- rr_ptr holds the last granted id. It resets to NUM_Q-1, so the first arbitration starts at queue 0.
- The FSM has three states: IDLE, ARB and REQ.
- IDLE -> ARB: enable=1 and any cnt != 0.
- ARB (one cycle):
  - Search from rr_ptr+1 upward, wrapping modulo NUM_Q, for the first queue with cnt != 0.
  - Latch that queue into id/len and update rr_ptr.
  - Go to REQ with valid=1.
  - If no queue is non-empty (cleared by a load), go to IDLE.
- REQ:
  - Hold valid, id and len constant until ready=1 is sampled.
  - On ready, decrement cnt[id], saturating at 0, and increment grant_total.
  - Then go to ARB if enable=1 and any remaining cnt != 0; otherwise go to IDLE.
  - done pulses when the post-update counts are all zero.
- A request is never retracted. Deasserting enable in REQ takes effect only after the handshake.
- When a load and a ready-decrement hit the same queue in the same cycle, the load wins and the decrement is dropped.
- A load of len to the queue currently in REQ does not change the presented len; it applies from the next request.
- ready sampled while valid=0 is ignored.

## Timing
- Reset values: valid=0, id=0, len=0, busy=0, done=0, grant_total=0; state is IDLE.
- enable rising with a non-empty queue: ARB on the next cycle, valid=1 two cycles after enable is sampled.
- ready sampled high in REQ: valid drops the following cycle (ARB), and the next valid appears one cycle later. The minimum ready-to-next-valid gap is 2 cycles, which matches the throttle's requirement that ready is low before it re-evaluates.
- done is asserted in the cycle after the final accepting ready, coincident with the return to IDLE.
- busy is asserted from the ARB entry through the REQ exit.
- reset asserted mid-REQ: all outputs take their reset values immediately (asynchronous), counts and rr_ptr clear, and no done is generated.

## Configuration
- THROTTLE_REQ_STATS_EN defined:
  - grant_total is a 32-bit counter that increments once per accepted request.
  - It wraps from 0xFFFFFFFF to 0.
  - It is cleared only by reset.
- Not defined: the grant_total port and its counter are absent; all other behaviour is identical.

## Test plan
- Load q0 cnt=3 len=2, enable=1, ready tied to a pulse two cycles after each valid rise -> three requests id=0 len=2, valid low for exactly one cycle between them, done pulse after the third, grant_total=3.
- Load q0, q1, q3 with cnt=2, q2 with cnt=0, immediate ready -> id order 0,1,3,0,1,3, q2 never selected, done after the sixth.
- Hold ready=0 for 20 cycles with valid=1, toggling enable and loading a new len to the active queue -> valid, id and len stay constant, and the new len appears on the next request.
- In the same cycle as the accepting ready for q1 (cnt=5), load q1 cnt=7 -> cnt[q1]=7 afterwards (load wins) and grant_total still increments.
- Load q2 cnt=1 with len=0 -> presented len=1.
- Assert reset while in REQ with counts pending -> valid=0, busy=0, done=0 immediately, and after reset release no request issues until a reload.
